// File: rtl/ldu_pkg.sv
// Shared types for the non-blocking load unit.
// Opcodes, MSHR state encoding and the MSHR entry layout.
package ldu_pkg;

    localparam int LDU_AW  = 16;
    localparam int LDU_DW  = 16;
    localparam int LDU_RSW = 6;

    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_LDR = 4'd5;

    typedef enum logic [1:0] {
        MSHR_FREE,
        MSHR_WAIT,
        MSHR_DONE
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e          state;
        logic [LDU_AW-1:0]    addr;
        logic [LDU_RSW-1:0]   tag;
        logic [3:0]           op;
        logic [LDU_DW-1:0]    data;
    } mshr_t;

endpackage

// File: rtl/ldu_fa_cache.sv
// Fully-associative data cache for the load unit.
// Ports: clk, rst_n (async active-low clear); lk_addr -> lk_hit/lk_data
// (combinational lookup); fill_en/fill_addr/fill_data (round-robin fill,
// in-place update when the address is already cached).
module ldu_fa_cache
    import ldu_pkg::*;
#(
    parameter int CACHE_ENTRIES = 4,
    parameter int AW            = 16,
    parameter int DW            = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_hit,
    output logic [DW-1:0] lk_data,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data
);

    localparam int PW = $clog2(CACHE_ENTRIES);

    logic [CACHE_ENTRIES-1:0] vld_q, vld_d;
    logic [AW-1:0]            tag_q [CACHE_ENTRIES];
    logic [AW-1:0]            tag_d [CACHE_ENTRIES];
    logic [DW-1:0]            dat_q [CACHE_ENTRIES];
    logic [DW-1:0]            dat_d [CACHE_ENTRIES];
    logic [PW-1:0]            rr_q, rr_d;

    logic                     in_place;
    logic [PW-1:0]            in_idx;

    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (vld_q[i] && tag_q[i] == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = dat_q[i];
            end
        end
    end

    always_comb begin
        in_place = 1'b0;
        in_idx   = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (vld_q[i] && tag_q[i] == fill_addr) begin
                in_place = 1'b1;
                in_idx   = PW'(i);
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        dat_d = dat_q;
        rr_d  = rr_q;
        if (fill_en) begin
            if (in_place) begin
                // Refill of a resident line: keep the victim pointer.
                dat_d[in_idx] = fill_data;
            end else begin
                vld_d[rr_q] = 1'b1;
                tag_d[rr_q] = fill_addr;
                dat_d[rr_q] = fill_data;
                if (rr_q == PW'(CACHE_ENTRIES - 1))
                    rr_d = '0;
                else
                    rr_d = rr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            rr_q  <= '0;
            for (int i = 0; i < CACHE_ENTRIES; i++) begin
                tag_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            rr_q  <= rr_d;
            tag_q <= tag_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/ld_nb_unit.sv
// Non-blocking LD/LDR unit: one lookup stage, FA cache, MSHR table.
// Ports: valid/rs_num/op/val0/val1 request (accepted when !busy);
// valid_out/rs_num_out/op_out/res_out result pulse (out of order);
// mem_re/mem_raddr request, mem_ready/mem_addr_out/mem_data_out
// shared broadcast; busy = stage held. Macro LDU_MERGE_EN lets a
// miss to an address already in flight take a secondary MSHR.
module ld_nb_unit
    import ldu_pkg::*;
#(
    parameter int AW            = LDU_AW,
    parameter int DW            = LDU_DW,
    parameter int RSW           = LDU_RSW,
    parameter int CACHE_ENTRIES = 4,
    parameter int NUM_MSHR      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid,
    input  logic [RSW-1:0] rs_num,
    input  logic [3:0]     op,
    input  logic [AW-1:0]  val0,
    input  logic [AW-1:0]  val1,
    output logic           valid_out,
    output logic [RSW-1:0] rs_num_out,
    output logic [3:0]     op_out,
    output logic [DW-1:0]  res_out,
    output logic [AW-1:0]  mem_raddr,
    output logic           mem_re,
    input  logic [AW-1:0]  mem_addr_out,
    input  logic [DW-1:0]  mem_data_out,
    input  logic           mem_ready,
    output logic           busy
);

`ifdef LDU_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

    localparam int MW = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    logic           stg_vld_q, stg_vld_d;
    logic [AW-1:0]  stg_addr_q, stg_addr_d;
    logic [RSW-1:0] stg_tag_q, stg_tag_d;
    logic [3:0]     stg_op_q, stg_op_d;

    mshr_t          mshr_q [NUM_MSHR];
    mshr_t          mshr_d [NUM_MSHR];

    logic           valid_out_q, valid_out_d;
    logic [RSW-1:0] rs_num_out_q, rs_num_out_d;
    logic [3:0]     op_out_q, op_out_d;
    logic [DW-1:0]  res_out_q, res_out_d;
    logic           mem_re_q, mem_re_d;
    logic [AW-1:0]  mem_raddr_q, mem_raddr_d;

    logic           c_hit;
    logic [DW-1:0]  c_data;
    logic           fill_en;

    logic           any_done, free_any, wait_hit;
    logic [MW-1:0]  done_idx, free_idx;
    logic           snarf, hit, stall, go;
    logic [DW-1:0]  hit_data;
    logic [AW-1:0]  req_addr;

    ldu_fa_cache #(
        .CACHE_ENTRIES (CACHE_ENTRIES),
        .AW            (AW),
        .DW            (DW)
    ) u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_addr   (stg_addr_q),
        .lk_hit    (c_hit),
        .lk_data   (c_data),
        .fill_en   (fill_en),
        .fill_addr (mem_addr_out),
        .fill_data (mem_data_out)
    );

    assign req_addr = (op == OP_LDR) ? val0 + val1 : val0;

    // Descending scans leave the lowest matching index.
    always_comb begin
        any_done = 1'b0;
        done_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        wait_hit = 1'b0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (mshr_q[i].state == MSHR_DONE) begin
                any_done = 1'b1;
                done_idx = MW'(i);
            end
            if (mshr_q[i].state == MSHR_FREE) begin
                free_any = 1'b1;
                free_idx = MW'(i);
            end
            if (mshr_q[i].state == MSHR_WAIT &&
                mshr_q[i].addr == stg_addr_q)
                wait_hit = 1'b1;
        end
    end

    // A broadcast of the stage address counts as a hit.
    assign snarf    = mem_ready && (mem_addr_out == stg_addr_q);
    assign hit      = snarf || c_hit;
    assign hit_data = snarf ? mem_data_out : c_data;

    // DONE entries own the output port, so the stage yields to them.
    assign stall = any_done
                || (!hit && !free_any)
                || (!hit && wait_hit && !MERGE_EN);
    assign busy  = stg_vld_q && stall;
    assign go    = stg_vld_q && !stall;

    always_comb begin
        stg_vld_d    = stg_vld_q;
        stg_addr_d   = stg_addr_q;
        stg_tag_d    = stg_tag_q;
        stg_op_d     = stg_op_q;
        mshr_d       = mshr_q;
        valid_out_d  = 1'b0;
        rs_num_out_d = rs_num_out_q;
        op_out_d     = op_out_q;
        res_out_d    = res_out_q;
        mem_re_d     = 1'b0;
        mem_raddr_d  = mem_raddr_q;
        fill_en      = 1'b0;

        for (int i = 0; i < NUM_MSHR; i++) begin
            if (mem_ready && mshr_q[i].state == MSHR_WAIT &&
                mshr_q[i].addr == mem_addr_out) begin
                mshr_d[i].state = MSHR_DONE;
                mshr_d[i].data  = mem_data_out;
                fill_en         = 1'b1;
            end
        end

        if (any_done) begin
            valid_out_d            = 1'b1;
            rs_num_out_d           = mshr_q[done_idx].tag;
            op_out_d               = mshr_q[done_idx].op;
            res_out_d              = mshr_q[done_idx].data;
            mshr_d[done_idx].state = MSHR_FREE;
        end else if (go && hit) begin
            valid_out_d  = 1'b1;
            rs_num_out_d = stg_tag_q;
            op_out_d     = stg_op_q;
            res_out_d    = hit_data;
        end else if (go) begin
            mshr_d[free_idx] = '{
                state: MSHR_WAIT,
                addr:  stg_addr_q,
                tag:   stg_tag_q,
                op:    stg_op_q,
                data:  '0
            };
            // A secondary entry rides on the primary's request.
            if (!wait_hit) begin
                mem_re_d    = 1'b1;
                mem_raddr_d = stg_addr_q;
            end
        end

        if (valid && !busy) begin
            stg_vld_d  = 1'b1;
            stg_addr_d = req_addr;
            stg_tag_d  = rs_num;
            stg_op_d   = op;
        end else if (go) begin
            stg_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld_q    <= 1'b0;
            stg_addr_q   <= '0;
            stg_tag_q    <= '0;
            stg_op_q     <= '0;
            valid_out_q  <= 1'b0;
            rs_num_out_q <= '0;
            op_out_q     <= '0;
            res_out_q    <= '0;
            mem_re_q     <= 1'b0;
            mem_raddr_q  <= '0;
            for (int i = 0; i < NUM_MSHR; i++)
                mshr_q[i] <= '0;
        end else begin
            stg_vld_q    <= stg_vld_d;
            stg_addr_q   <= stg_addr_d;
            stg_tag_q    <= stg_tag_d;
            stg_op_q     <= stg_op_d;
            valid_out_q  <= valid_out_d;
            rs_num_out_q <= rs_num_out_d;
            op_out_q     <= op_out_d;
            res_out_q    <= res_out_d;
            mem_re_q     <= mem_re_d;
            mem_raddr_q  <= mem_raddr_d;
            mshr_q       <= mshr_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign rs_num_out = rs_num_out_q;
    assign op_out     = op_out_q;
    assign res_out    = res_out_q;
    assign mem_re     = mem_re_q;
    assign mem_raddr  = mem_raddr_q;

endmodule

// File: tb/tb_ld_nb_unit.sv
// Bench for ld_nb_unit: directed scenarios plus a random phase,
// checked against a per-tag expected-result model and memory function.
module tb_ld_nb_unit;
    import ldu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [5:0]  rs_num;
    logic [3:0]  op;
    logic [15:0] val0, val1;
    logic        valid_out;
    logic [5:0]  rs_num_out;
    logic [3:0]  op_out;
    logic [15:0] res_out;
    logic [15:0] mem_raddr;
    logic        mem_re;
    logic [15:0] mem_addr_out, mem_data_out;
    logic        mem_ready;
    logic        busy;

    ld_nb_unit #(
        .AW(16), .DW(16), .RSW(6),
        .CACHE_ENTRIES(4), .NUM_MSHR(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .rs_num       (rs_num),
        .op           (op),
        .val0         (val0),
        .val1         (val1),
        .valid_out    (valid_out),
        .rs_num_out   (rs_num_out),
        .op_out       (op_out),
        .res_out      (res_out),
        .mem_raddr    (mem_raddr),
        .mem_re       (mem_re),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Model: loads in flight, keyed by tag.
    bit          pend      [64];
    logic [15:0] pend_addr [64];
    logic [3:0]  pend_op   [64];
    int          n_pend = 0;

    typedef struct packed {
        logic [5:0]  tag;
        logic [15:0] res;
        int          c;
    } res_t;

    res_t        out_q [$];
    logic [15:0] req_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return (a ^ 16'h5A5A) + 16'h0101;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_re)
            req_q.push_back(mem_raddr);
        if (rst_n && valid_out) begin
            chk("res_tag_live", 32'(pend[rs_num_out]), 1);
            chk("res_data", 32'(res_out),
                32'(mem_fn(pend_addr[rs_num_out])));
            chk("res_op", 32'(op_out), 32'(pend_op[rs_num_out]));
            if (pend[rs_num_out]) n_pend--;
            pend[rs_num_out] = 1'b0;
            out_q.push_back('{rs_num_out, res_out, cyc});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [5:0]  tag,
                         input logic [3:0]  o,
                         input logic [15:0] v0,
                         input logic [15:0] v1);
        int guard;
        guard  = 0;
        valid  = 1'b1;
        rs_num = tag;
        op     = o;
        val0   = v0;
        val1   = v1;
        while (busy && guard < 300) begin
            tick();
            guard++;
        end
        if (busy) begin
            chk("issue_timeout", 0, 1);
            valid = 1'b0;
            return;
        end
        pend[tag]      = 1'b1;
        pend_addr[tag] = (o == OP_LDR) ? v0 + v1 : v0;
        pend_op[tag]   = o;
        n_pend++;
        @(posedge clk);
        #1;
        valid = 1'b0;
        tick();
    endtask

    task automatic drop_req(input logic [15:0] a);
        for (int i = req_q.size() - 1; i >= 0; i--)
            if (req_q[i] == a) req_q.delete(i);
    endtask

    task automatic bcast(input logic [15:0] a);
        mem_ready    = 1'b1;
        mem_addr_out = a;
        mem_data_out = mem_fn(a);
        drop_req(a);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] pool [8];
        logic [5:0]  tagc;
        int          guard;
        int          idx;

        for (int k = 0; k < 8; k++)
            pool[k] = 16'h0800 + 16'(k * 16);

        rst_n = 1'b0;
        valid = 1'b0;
        rs_num = '0;
        op = OP_LD;
        val0 = '0;
        val1 = '0;
        mem_ready = 1'b0;
        mem_addr_out = '0;
        mem_data_out = '0;
        ticks(3);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_out", 32'(res_out), 0);
        chk("rst_mem_raddr", 32'(mem_raddr), 0);
        rst_n = 1'b1;
        tick();

        // Cold miss
        issue(6'd3, OP_LD, 16'h0040, 16'h1234);
        chk("cold_no_re_n1", 32'(mem_re), 0);
        tick();
        chk("cold_re_n2", 32'(mem_re), 1);
        chk("cold_raddr", 32'(mem_raddr), 32'h0040);
        tick();
        chk("cold_re_pulse", 32'(mem_re), 0);
        ticks(97);
        chk("cold_no_early", 32'(valid_out), 0);
        bcast(16'h0040);
        chk("cold_vout_b1", 32'(valid_out), 0);
        tick();
        chk("cold_vout", 32'(valid_out), 1);
        chk("cold_tag", 32'(rs_num_out), 3);
        chk("cold_res", 32'(res_out), 32'hBEEF);
        tick();
        chk("cold_vout_pulse", 32'(valid_out), 0);

        // Hit through LDR
        issue(6'd7, OP_LDR, 16'h0030, 16'h0010);
        chk("hit_vout_n1", 32'(valid_out), 0);
        chk("hit_re_n1", 32'(mem_re), 0);
        tick();
        chk("hit_vout", 32'(valid_out), 1);
        chk("hit_tag", 32'(rs_num_out), 7);
        chk("hit_res", 32'(res_out), 32'hBEEF);
        chk("hit_op", 32'(op_out), 32'(OP_LDR));
        chk("hit_re", 32'(mem_re), 0);
        tick();
        chk("hit_vout_pulse", 32'(valid_out), 0);

        // Out-of-order completion
        out_q.delete();
        req_q.delete();
        issue(6'd1, OP_LD, 16'h0010, 16'h0000);
        issue(6'd2, OP_LD, 16'h0020, 16'h0000);
        ticks(2);
        chk("ooo_req_cnt", req_q.size(), 2);
        if (req_q.size() == 2) begin
            chk("ooo_req0", 32'(req_q[0]), 32'h0010);
            chk("ooo_req1", 32'(req_q[1]), 32'h0020);
        end
        bcast(16'h0020);
        tick();
        bcast(16'h0010);
        ticks(3);
        chk("ooo_out_cnt", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("ooo_first", 32'(out_q[0].tag), 2);
            chk("ooo_second", 32'(out_q[1].tag), 1);
        end

        // MSHR full
        out_q.delete();
        req_q.delete();
        for (int k = 0; k < 5; k++)
            issue(6'(10 + k), OP_LD, 16'(16'h0100 * (k + 1)), 16'h0);
        chk("full_busy", 32'(busy), 1);
        ticks(5);
        chk("full_busy_hold", 32'(busy), 1);
        chk("full_req_cnt", req_q.size(), 4);
        bcast(16'h0100);
        guard = 0;
        while (req_q.size() < 4 && guard < 20) begin
            tick();
            guard++;
        end
        chk("full_5th_issued", req_q.size(), 4);
        if (req_q.size() == 4)
            chk("full_5th_addr", 32'(req_q[3]), 32'h0500);
        chk("full_busy_clear", 32'(busy), 0);
        for (int k = 1; k < 5; k++) begin
            bcast(16'(16'h0100 * (k + 1)));
            tick();
        end
        ticks(3);
        chk("full_out_cnt", out_q.size(), 5);
        chk("full_none_lost", n_pend, 0);

        // Same-address misses
        out_q.delete();
        req_q.delete();
        issue(6'd4, OP_LD, 16'h0050, 16'h0000);
        issue(6'd5, OP_LD, 16'h0050, 16'h0000);
`ifdef LDU_MERGE_EN
        chk("merge_busy", 32'(busy), 0);
`else
        chk("merge_busy", 32'(busy), 1);
`endif
        ticks(5);
        chk("merge_one_req", req_q.size(), 1);
        bcast(16'h0050);
        ticks(3);
        chk("merge_out_cnt", out_q.size(), 2);
        if (out_q.size() == 2) begin
`ifdef LDU_MERGE_EN
            chk("merge_first", 32'(out_q[0].tag), 4);
            chk("merge_second", 32'(out_q[1].tag), 5);
`else
            chk("merge_first", 32'(out_q[0].tag), 5);
            chk("merge_second", 32'(out_q[1].tag), 4);
`endif
            chk("merge_consec", out_q[1].c - out_q[0].c, 1);
        end

        // Reset with loads in flight
        out_q.delete();
        req_q.delete();
        issue(6'd20, OP_LD, 16'h0600, 16'h0000);
        issue(6'd21, OP_LD, 16'h0700, 16'h0000);
        ticks(3);
        chk("rst2_req_cnt", req_q.size(), 2);
        rst_n = 1'b0;
        #1;
        chk("rst2_valid_out", 32'(valid_out), 0);
        chk("rst2_mem_re", 32'(mem_re), 0);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_res_out", 32'(res_out), 0);
        chk("rst2_mem_raddr", 32'(mem_raddr), 0);
        for (int t = 0; t < 64; t++) pend[t] = 1'b0;
        n_pend = 0;
        ticks(2);
        rst_n = 1'b1;
        tick();
        bcast(16'h0600);
        bcast(16'h0700);
        ticks(4);
        chk("rst2_ignored", out_q.size(), 0);
        req_q.delete();
        issue(6'd22, OP_LD, 16'h0600, 16'h0000);
        tick();
        chk("rst2_remiss", 32'(mem_re), 1);
        chk("rst2_remiss_addr", 32'(mem_raddr), 32'h0600);
        bcast(16'h0600);
        ticks(3);
        chk("rst2_out_cnt", out_q.size(), 1);
        if (out_q.size() == 1)
            chk("rst2_tag", 32'(out_q[0].tag), 22);

        // Random traffic
        out_q.delete();
        req_q.delete();
        tagc = 6'd0;
        for (int it = 0; it < 600; it++) begin
            mem_ready = 1'b0;
            if (req_q.size() > 0 && $urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, req_q.size() - 1));
                a = req_q[idx];
                mem_ready = 1'b1;
                mem_addr_out = a;
                mem_data_out = mem_fn(a);
                drop_req(a);
            end else if ($urandom_range(0, 15) == 0) begin
                a = pool[$urandom_range(0, 7)];
                mem_ready = 1'b1;
                mem_addr_out = a;
                mem_data_out = mem_fn(a);
                drop_req(a);
            end
            valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                a = pool[$urandom_range(0, 7)];
                valid = 1'b1;
                rs_num = tagc;
                val1 = 16'($urandom_range(0, 16'hFFFF));
                if ($urandom_range(0, 1) == 1) begin
                    op = OP_LDR;
                    val0 = a - val1;
                end else begin
                    op = OP_LD;
                    val0 = a;
                end
            end
            #1;
            if (valid && !busy) begin
                pend[tagc] = 1'b1;
                pend_addr[tagc] = a;
                pend_op[tagc] = op;
                n_pend++;
                tagc = tagc + 6'd1;
            end
            @(posedge clk);
            #1;
            valid = 1'b0;
            mem_ready = 1'b0;
            tick();
        end
        guard = 0;
        while ((n_pend > 0 || req_q.size() > 0) && guard < 3000) begin
            if (req_q.size() > 0 && $urandom_range(0, 1) == 1)
                bcast(req_q[0]);
            else
                tick();
            guard++;
        end
        ticks(4);
        chk("rand_drained", n_pend, 0);
        chk("rand_no_req_left", req_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
